// File: rtl/down_counter_pkg.sv
// down_counter_pkg: state encoding and default width shared by the down_counter block.
package down_counter_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/down_counter.sv
// down_counter: loadable countdown timer with valid/ready load, terminal-count pulse and done status.
// Define DOWN_COUNTER_RELOAD_EN for periodic operation (auto-reload on terminal count).
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             load_acc;

    assign load_ready = (state_q != RUN) && !abort;
    assign load_acc   = load_valid && load_ready;
    assign count      = count_q;
    assign busy       = state_q == RUN;
    assign done       = state_q == DONE;
    assign tc         = tc_q;

`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;

    always_comb begin
        reload_d = (load_acc && load_value != '0) ? load_value : reload_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) reload_q <= '0;
        else        reload_q <= reload_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (load_acc) begin
            count_d = load_value;
            state_d = (load_value != '0) ? RUN : DONE;
            tc_d    = load_value == '0;
        end else if (state_q == RUN && enable) begin
            if (count_q <= WIDTH'(1)) begin
                tc_d = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
                count_d = reload_q;
`else
                count_d = '0;
                state_d = DONE;
`endif
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

endmodule
